// File: rtl/bcd_display_scan_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3) driving a time-multiplexed 7-segment display.
// Optional macro BCD_BLANK_LEADING_ZERO_EN turns off digits above the most-significant non-zero one.
module bcd_display_scan_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned BIN_W    = 14,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [BIN_W-1:0]  bin_i,
  output logic              busy_o,
  output logic              ready_o,
  output logic [3:0]        bcd_nib_o,
  input  logic [6:0]        seg_in_i,
  output logic [6:0]        seg_o,
  output logic [DIGITS-1:0] an_o
);

  localparam int unsigned NibW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PreW = $clog2(SCAN_DIV);

  function automatic logic [31:0] max_dec(input int unsigned n);
    logic [31:0] r;
    r = 32'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 32'd10;
    return r - 32'd1;
  endfunction

  localparam logic [31:0] SatMax = max_dec(DIGITS);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e            state_q;
  logic [BIN_W-1:0]  shift_q;
  logic [NibW-1:0]   bcd_q;
  logic [CntW-1:0]   cnt_q;
  logic [NibW-1:0]   disp_q;
  logic              ready_q;
  logic [PreW-1:0]   presc_q;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0] an_q;

  logic [31:0]      bin_ext;
  logic [BIN_W-1:0] bin_sat;
  logic [NibW-1:0]  bcd_adj;

  assign bin_ext = 32'(bin_i);

  always_comb begin
    bin_sat = bin_i;
    if (bin_ext > SatMax) bin_sat = SatMax[BIN_W-1:0];
  end

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_i) begin
            shift_q <= bin_sat;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= StConv;
          end
        end
        StConv: begin
          {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
          if (cnt_q == CntW'(BIN_W - 1)) state_q <= StDone;
          else                           cnt_q   <= cnt_q + CntW'(1);
        end
        StDone: begin
          disp_q  <= bcd_q;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o  = (state_q != StIdle);
  assign ready_o = ready_q;

  always_comb begin
    idx_d = idx_q;
    if (presc_q == PreW'(SCAN_DIV - 1)) begin
      idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end
  end

  // Scan timing free-runs regardless of conversion state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= ~DIGITS'(1);
    end else begin
      presc_q <= (presc_q == PreW'(SCAN_DIV - 1)) ? '0 : presc_q + PreW'(1);
      idx_q   <= idx_d;
      an_q    <= ~(DIGITS'(1) << idx_d);
    end
  end

  assign bcd_nib_o = disp_q[{idx_q, 2'b00} +: 4];

`ifdef BCD_BLANK_LEADING_ZERO_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              seen;

  // Digit 0 is never blank, so zero shows as a single "0".
  always_comb begin
    blank_d = '0;
    seen    = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (bcd_q[4*i +: 4] != 4'd0) seen = 1'b1;
      blank_d[i] = !seen;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 blank_q <= ~DIGITS'(1);
    else if (state_q == StDone) blank_q <= blank_d;
  end

  assign an_o  = an_q | blank_q;
  assign seg_o = blank_q[idx_q] ? 7'b0000000 : seg_in_i;
`else
  assign an_o  = an_q;
  assign seg_o = seg_in_i;
`endif

endmodule

// File: tb/tb_bcd_display_scan_ctrl.sv
// Scoreboard bench for bcd_display_scan_ctrl: stimulus pushes expected display values,
// a negedge monitor checks ready timing, busy and the scanned display against a decimal model.
module tb_bcd_display_scan_ctrl;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned BIN_W    = 14;
  localparam int unsigned SCAN_DIV = 4;
  localparam int          LAT      = BIN_W + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              load = 1'b0;
  logic [BIN_W-1:0]  bin = '0;
  logic              busy, ready;
  logic [3:0]        bcd_nib;
  logic [6:0]        seg_in, seg;
  logic [DIGITS-1:0] an;

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t sb[$];
  int   model_disp = 0;
  int   edges = 0;
  int   total = 0;
  int   passed = 0;

  bcd_display_scan_ctrl #(
    .DIGITS  (DIGITS),
    .BIN_W   (BIN_W),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .load_i   (load),
    .bin_i    (bin),
    .busy_o   (busy),
    .ready_o  (ready),
    .bcd_nib_o(bcd_nib),
    .seg_in_i (seg_in),
    .seg_o    (seg),
    .an_o     (an)
  );

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v > pow10(DIGITS) - 1) ? pow10(DIGITS) - 1 : v;
  endfunction

  assign seg_in = dec7(bcd_nib);

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t              e;
    int                idx, dig;
    logic              blank;
    logic [DIGITS-1:0] exp_an;
    logic [6:0]        exp_seg;
    if (ready) begin
      chk("ready_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ready_latency", edges, e.due);
        model_disp = e.val;
      end
    end else if (sb.size() > 0 && edges > sb[0].due) begin
      chk("ready_timeout", edges, sb[0].due);
      void'(sb.pop_front());
    end
    chk("busy", int'(busy), int'(sb.size() != 0));
    idx   = (edges / SCAN_DIV) % DIGITS;
    dig   = (model_disp / pow10(idx)) % 10;
    blank = 1'b0;
`ifdef BCD_BLANK_LEADING_ZERO_EN
    blank = (idx > 0) && (model_disp < pow10(idx));
`endif
    exp_an  = blank ? '1 : ~(DIGITS'(1) << idx);
    exp_seg = blank ? 7'h00 : dec7(4'(dig));
    chk("an", int'(an), int'(exp_an));
    chk("bcd_nib", int'(bcd_nib), dig);
    chk("seg", int'(seg), int'(exp_seg));
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_load(input int v);
    bit   accepted;
    exp_t e;
    @(negedge clk);
    #2;
    load     = 1'b1;
    bin      = v[BIN_W-1:0];
    accepted = (sb.size() == 0);
    @(posedge clk);
    #1;
    if (accepted) begin
      e.val = sat(v);
      e.due = edges + LAT;
      sb.push_back(e);
    end
    load = 1'b0;
  endtask

  initial begin
    int v;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(20);

    do_load(1234);
    idle(30);
    do_load(16383);
    idle(20);
    do_load(42);
    idle(2);
    do_load(777);
    idle(30);

    do_load(500);
    repeat (7) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n      = 1'b0;
    sb.delete();
    model_disp = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    do_load(500);
    idle(30);

    do_load(7);
    idle(30);
    do_load(0);
    idle(20);

    for (int i = 0; i < 25; i++) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 99))
                                      : int'($urandom_range(0, 16383));
      do_load(v);
      idle(int'($urandom_range(0, 25)));
    end

    idle(40);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
